// File: rtl/logic_seq_32.sv
// Slice-serial 32-bit bitwise logic unit: SLICE_W bits of AND/OR/XOR/NOR per cycle, LSB slice first.
// Optional macro LOGIC_ZERO_FLAG_EN builds a registered result-is-zero flag; otherwise zero is tied low.
module logic_seq_32 #(
  parameter int SLICE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res,
  output logic        busy,
  output logic        done,
  output logic        zero
);

  localparam int N     = 32 / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]         op_q, op_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [31:0]        op_res;
  logic               last;

  // Full-width result of the latched operation; RUN picks out one slice per cycle.
  always_comb begin
    op_res = '0;
    case (op_q)
      2'b00:   op_res = a_q & b_q;
      2'b01:   op_res = a_q | b_q;
      2'b10:   op_res = a_q ^ b_q;
      default: op_res = ~(a_q | b_q);
    endcase
  end

  assign last = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++)
          if (cnt_q == CNT_W'(i))
            res_d[i*SLICE_W +: SLICE_W] = op_res[i*SLICE_W +: SLICE_W];
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef LOGIC_ZERO_FLAG_EN
  logic zero_q, zero_d;

  // Cleared on accept, evaluated on the cycle the final slice lands.
  always_comb begin
    zero_d = zero_q;
    if (state_q == IDLE && start)
      zero_d = 1'b0;
    else if (state_q == RUN && last)
      zero_d = (res_d == 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) zero_q <= 1'b0;
    else       zero_q <= zero_d;
  end

  assign zero = zero_q;
`else
  assign zero = 1'b0;
`endif

  assign res  = res_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
